wb_arbiter_mp: RTL

- Parametrised writeback arbiter/buffer between NUM_PIPES execution pipelines and two write ports: scalar register file (one write/cycle) and vector register file (one masked write/cycle).
- Sits at the end of the WB stage.
- Generalises the two-pipe scalar/vector writeback select to N sources, each with per-port FIFO buffering.
- Uses round-robin arbitration, backpressure for stallable pipes and overflow detection for non-stallable pipes.

---
 rtl/wb_arbiter_mp_if.sv | 37 +++
 rtl/wb_arbiter_mp.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_mp_if.sv
// Writeback request/response bundle between NUM_PIPES execution pipes and the
// scalar/vector register-file write ports. Per-pipe fields are packed [pipe][field].
interface wb_arbiter_mp_if #(
  parameter int NUM_PIPES = 2,
  parameter int SDATA_W   = 36,
  parameter int VDATA_W   = 128,
  parameter int VLANES    = 4,
  parameter int ADDR_W    = 5
);
  logic [NUM_PIPES-1:0]              s_valid;
  logic [NUM_PIPES-1:0][ADDR_W-1:0]  s_addr;
  logic [NUM_PIPES-1:0][SDATA_W-1:0] s_data;
  logic [NUM_PIPES-1:0]              v_valid;
  logic [NUM_PIPES-1:0][ADDR_W-1:0]  v_addr;
  logic [NUM_PIPES-1:0][VDATA_W-1:0] v_data;
  logic [NUM_PIPES-1:0][VLANES-1:0]  v_mask;
  logic [NUM_PIPES-1:0]              pipe_ready;
  logic                              register_we;
  logic [ADDR_W-1:0]                 register_addr;
  logic [SDATA_W-1:0]                register_data;
  logic [VLANES-1:0]                 vector_we;
  logic [ADDR_W-1:0]                 vector_addr;
  logic [VDATA_W-1:0]                vector_data;
  logic [NUM_PIPES-1:0]              overflow;
  logic                              idle;

  modport slave (
    input  s_valid, s_addr, s_data, v_valid, v_addr, v_data, v_mask,
    output pipe_ready, register_we, register_addr, register_data,
           vector_we, vector_addr, vector_data, overflow, idle
  );
  modport master (
    output s_valid, s_addr, s_data, v_valid, v_addr, v_data, v_mask,
    input  pipe_ready, register_we, register_addr, register_data,
           vector_we, vector_addr, vector_data, overflow, idle
  );
endinterface

// File: rtl/wb_arbiter_mp.sv
// Writeback arbiter: per-pipe FIFOs feeding independent round-robin scalar and
// vector register-file write ports, with same-cycle bypass when a FIFO is empty.

module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           rp, wp;
  logic [CW-1:0]           cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wp] <= din;

  assign dout  = mem[rp];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
endmodule

// One write port: NP in-order FIFOs plus a round-robin pick among their heads
// (or the live request when a pipe's FIFO is empty).
module wb_arb_port #(
  parameter int NP    = 2,
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NP-1:0]       valid,
  input  logic [NP-1:0][W-1:0] din,
  output logic                gnt,
  output logic [W-1:0]        dout,
  output logic [NP-1:0]       full,
  output logic [NP-1:0]       empty,
  output logic [NP-1:0]       drop
);
  localparam int PW = $clog2(NP);
  logic [PW-1:0]        ptr, gidx, idx;
  logic                 found;
  logic [NP-1:0]        cand;
  logic [NP-1:0][W-1:0] head;

  assign cand = valid | ~empty;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    for (int k = 0; k < NP; k++) begin
      idx = PW'((int'(ptr) + k) % NP);
      if (!found && cand[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
  end

  // Gated by reset so a live bypass request cannot write while held in reset.
  assign gnt  = found & rst;
  assign dout = gnt ? (empty[gidx] ? din[gidx] : head[gidx]) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ptr <= '0;
    else if (gnt) ptr <= (int'(gidx) == NP-1) ? '0 : gidx + PW'(1);
  end

  for (genvar i = 0; i < NP; i++) begin : g_pipe
    logic sel, pop, byp, push;
    assign sel  = gnt && (gidx == PW'(i));
    assign pop  = sel && !empty[i];
    assign byp  = sel && empty[i];
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push    = valid[i] && !byp && (!full[i] || pop);
    assign drop[i] = valid[i] && !byp && full[i] && !pop;

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din[i]),
      .dout(head[i]), .empty(empty[i]), .full(full[i])
    );
  end
endmodule

module wb_arbiter_mp #(
  parameter int                   NUM_PIPES  = 2,
  parameter int                   SDATA_W    = 36,
  parameter int                   VDATA_W    = 128,
  parameter int                   VLANES     = 4,
  parameter int                   ADDR_W     = 5,
  parameter int                   BUF_DEPTH  = 4,
  parameter logic [NUM_PIPES-1:0] STALL_MASK = 'b01
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_mp_if.slave bus
);
  localparam int SW = ADDR_W + SDATA_W;
  localparam int VW = VLANES + ADDR_W + VDATA_W;

  logic [NUM_PIPES-1:0][SW-1:0] s_pkt;
  logic [NUM_PIPES-1:0][VW-1:0] v_pkt;
  logic [SW-1:0]                s_win;
  logic [VW-1:0]                v_win;
  logic                         s_gnt, v_gnt;
  logic [NUM_PIPES-1:0]         sfull, vfull, sempty, vempty, sdrop, vdrop, ovf;

  // Stallability only changes source behaviour; a request arriving at a full
  // FIFO is dropped and flagged the same way for every pipe.
  logic unused_stall;
  assign unused_stall = ^STALL_MASK;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pkt
    assign s_pkt[i] = {bus.s_addr[i], bus.s_data[i]};
    assign v_pkt[i] = {bus.v_mask[i], bus.v_addr[i], bus.v_data[i]};
  end

  wb_arb_port #(.NP(NUM_PIPES), .W(SW), .DEPTH(BUF_DEPTH)) u_sport (
    .clk(clk), .rst(rst), .valid(bus.s_valid), .din(s_pkt), .gnt(s_gnt),
    .dout(s_win), .full(sfull), .empty(sempty), .drop(sdrop)
  );

  wb_arb_port #(.NP(NUM_PIPES), .W(VW), .DEPTH(BUF_DEPTH)) u_vport (
    .clk(clk), .rst(rst), .valid(bus.v_valid), .din(v_pkt), .gnt(v_gnt),
    .dout(v_win), .full(vfull), .empty(vempty), .drop(vdrop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= '0;
    else      ovf <= ovf | sdrop | vdrop;
  end

  assign bus.pipe_ready    = ~(sfull | vfull);
  assign bus.register_we   = s_gnt;
  assign bus.register_addr = s_win[SDATA_W +: ADDR_W];
  assign bus.register_data = s_win[SDATA_W-1:0];
  assign bus.vector_we     = v_gnt ? v_win[VW-1 -: VLANES] : '0;
  assign bus.vector_addr   = v_win[VDATA_W +: ADDR_W];
  assign bus.vector_data   = v_win[VDATA_W-1:0];
  assign bus.overflow      = ovf;
  assign bus.idle          = (&sempty) & (&vempty);
endmodule
